// File: rtl/lsu_bus_ctrl_if.sv
// Request/grant memory bus between the load/store unit (master) and the memory
// fabric (slave), with in-order responses.
interface lsu_bus_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              bus_req_o;
  logic              bus_gnt_i;
  logic              bus_we_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [DATA_W-1:0] bus_wdata_o;
  logic [3:0]        bus_wmask_o;
  logic              bus_rvalid_i;
  logic [DATA_W-1:0] bus_rdata_i;
  logic              bus_err_i;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wmask_o,
    input  bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wmask_o,
    output bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i
  );
endinterface

// File: rtl/lsu_bus_ctrl.sv
// Memory-stage bus controller: one-entry holding slot, in-order outstanding
// tracking with flush kill bits, and registered aligned load writeback.
module lsu_bus_ctrl #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [3:0]        req_wmask_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_signed_i,
  input  logic [4:0]        req_rd_i,
  input  logic              flush_i,
  lsu_bus_ctrl_if.master    bus,
  output logic              wb_we_o,
  output logic [4:0]        wb_waddr_o,
  output logic [31:0]       wb_wdata_o,
  output logic              err_o,
  output logic              lsu_idle_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef struct packed {
    logic       we;
    logic [1:0] lane;
    logic [1:0] size;
    logic       sgn;
    logic [4:0] rd;
    logic       kill;
  } meta_t;

  logic              hold_vld_q, hold_vld_d;
  logic              hold_we_q, hold_we_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [DATA_W-1:0] hold_wdata_q, hold_wdata_d;
  logic [3:0]        hold_wmask_q, hold_wmask_d;
  logic [1:0]        hold_size_q, hold_size_d;
  logic              hold_signed_q, hold_signed_d;
  logic [4:0]        hold_rd_q, hold_rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  meta_t             meta_q [MAX_OUTSTANDING];
  meta_t             meta_d [MAX_OUTSTANDING];
  logic              wb_we_q, wb_we_d;
  logic [4:0]        wb_waddr_q, wb_waddr_d;
  logic [31:0]       wb_wdata_q, wb_wdata_d;
  logic              err_q, err_d;

  logic  accept, issue, grant, resp, live;
  meta_t head;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign accept = req_valid_i & ~hold_vld_q & ~flush_i;
  assign issue  = hold_vld_q & (cnt_q < CNT_W'(MAX_OUTSTANDING)) & ~flush_i;
  assign grant  = issue & bus.bus_gnt_i;
  // A response with nothing outstanding is spurious and must not touch state.
  assign resp   = bus.bus_rvalid_i & (cnt_q != '0);
  assign head   = meta_q[rd_ptr_q];
  assign live   = resp & ~head.kill & ~flush_i;

  assign req_ready_o     = ~hold_vld_q;
  assign lsu_idle_o      = ~hold_vld_q & (cnt_q == '0);
  assign bus.bus_req_o   = issue;
  assign bus.bus_we_o    = hold_we_q;
  assign bus.bus_addr_o  = hold_addr_q;
  assign bus.bus_wdata_o = hold_wdata_q;
  assign bus.bus_wmask_o = hold_wmask_q;
  assign wb_we_o         = wb_we_q;
  assign wb_waddr_o      = wb_waddr_q;
  assign wb_wdata_o      = wb_wdata_q;
  assign err_o           = err_q;

  always_comb begin
    ld_byte = 8'h00;
    ld_half = head.lane[1] ? bus.bus_rdata_i[31:16] : bus.bus_rdata_i[15:0];
    case (head.lane)
      2'd0:    ld_byte = bus.bus_rdata_i[7:0];
      2'd1:    ld_byte = bus.bus_rdata_i[15:8];
      2'd2:    ld_byte = bus.bus_rdata_i[23:16];
      default: ld_byte = bus.bus_rdata_i[31:24];
    endcase
    case (head.size)
      2'b00:   ld_data = {{24{head.sgn & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{head.sgn & ld_half[15]}}, ld_half};
      default: ld_data = bus.bus_rdata_i;
    endcase
  end

  always_comb begin
    hold_vld_d    = hold_vld_q;
    hold_we_d     = hold_we_q;
    hold_addr_d   = hold_addr_q;
    hold_wdata_d  = hold_wdata_q;
    hold_wmask_d  = hold_wmask_q;
    hold_size_d   = hold_size_q;
    hold_signed_d = hold_signed_q;
    hold_rd_d     = hold_rd_q;
    cnt_d         = cnt_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    meta_d        = meta_q;
    wb_we_d       = 1'b0;
    wb_waddr_d    = wb_waddr_q;
    wb_wdata_d    = wb_wdata_q;
    err_d         = live & bus.bus_err_i;

    if (flush_i || grant) begin
      hold_vld_d = 1'b0;
    end else if (accept) begin
      hold_vld_d    = 1'b1;
      hold_we_d     = req_we_i;
      hold_addr_d   = req_addr_i;
      hold_wdata_d  = req_wdata_i;
      hold_wmask_d  = req_wmask_i;
      hold_size_d   = req_size_i;
      hold_signed_d = req_signed_i;
      hold_rd_d     = req_rd_i;
    end

    // Flush squashes everything in flight; entries pushed later are live.
    if (flush_i) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) meta_d[i].kill = 1'b1;
    end
    if (grant) begin
      meta_d[wr_ptr_q] = '{we: hold_we_q, lane: hold_addr_q[1:0], size: hold_size_q,
                           sgn: hold_signed_q, rd: hold_rd_q, kill: 1'b0};
      wr_ptr_d = next_ptr(wr_ptr_q);
    end
    if (resp) rd_ptr_d = next_ptr(rd_ptr_q);

    case ({grant, resp})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    if (live && !bus.bus_err_i && !head.we) begin
      wb_we_d    = (head.rd != 5'd0);
      wb_waddr_d = head.rd;
      wb_wdata_d = ld_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_vld_q    <= 1'b0;
      hold_we_q     <= 1'b0;
      hold_addr_q   <= '0;
      hold_wdata_q  <= '0;
      hold_wmask_q  <= '0;
      hold_size_q   <= '0;
      hold_signed_q <= 1'b0;
      hold_rd_q     <= '0;
      cnt_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      meta_q        <= '{default: '0};
      wb_we_q       <= 1'b0;
      wb_waddr_q    <= '0;
      wb_wdata_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      hold_vld_q    <= hold_vld_d;
      hold_we_q     <= hold_we_d;
      hold_addr_q   <= hold_addr_d;
      hold_wdata_q  <= hold_wdata_d;
      hold_wmask_q  <= hold_wmask_d;
      hold_size_q   <= hold_size_d;
      hold_signed_q <= hold_signed_d;
      hold_rd_q     <= hold_rd_d;
      cnt_q         <= cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      meta_q        <= meta_d;
      wb_we_q       <= wb_we_d;
      wb_waddr_q    <= wb_waddr_d;
      wb_wdata_q    <= wb_wdata_d;
      err_q         <= err_d;
    end
  end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Directed bench for lsu_bus_ctrl: a queue-based transaction model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_lsu_bus_ctrl;

  localparam int MAX = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_we_i, req_signed_i, flush_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [3:0]  req_wmask_i;
  logic [1:0]  req_size_i;
  logic [4:0]  req_rd_i;
  logic        req_ready_o, wb_we_o, err_o, lsu_idle_o;
  logic [4:0]  wb_waddr_o;
  logic [31:0] wb_wdata_o;

  int checks   = 0;
  int failures = 0;

  lsu_bus_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  lsu_bus_ctrl #(.ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wmask_i(req_wmask_i),
    .req_size_i(req_size_i), .req_signed_i(req_signed_i), .req_rd_i(req_rd_i),
    .flush_i(flush_i), .bus(bus),
    .wb_we_o(wb_we_o), .wb_waddr_o(wb_waddr_o), .wb_wdata_o(wb_wdata_o),
    .err_o(err_o), .lsu_idle_o(lsu_idle_o)
  );

  always #5 clk = ~clk;

  // Transaction-level model: a held request plus a queue of in-flight entries.
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [1:0]  size;
    logic        sgn;
    logic [4:0]  rd;
  } req_t;

  typedef struct {
    logic       we;
    logic [1:0] lane;
    logic [1:0] size;
    logic       sgn;
    logic [4:0] rd;
    logic       kill;
  } ent_t;

  ent_t        m_q[$];
  req_t        m_hold;
  bit          m_hold_vld = 0;
  bit          m_wb_we = 0;
  bit          m_err = 0;
  logic [4:0]  m_wb_addr = '0;
  logic [31:0] m_wb_data = '0;
  bit          mdl_was_hold, mdl_issue;
  ent_t        mdl_e;

  function automatic logic [31:0] model_align(input logic [31:0] d, input logic [1:0] lane,
                                              input logic [1:0] size, input logic sgn);
    int nbytes, off;
    logic [31:0] v, upper;
    nbytes = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    off    = (size == 2'b00) ? int'(lane) : (size == 2'b01) ? (int'(lane) & 2) : 0;
    v      = d >> (8 * off);
    if (nbytes < 4) begin
      upper = 32'hFFFF_FFFF << (8 * nbytes);
      if (sgn && v[8*nbytes-1]) v = v | upper;
      else                      v = v & ~upper;
    end
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hold_vld = 0;
      m_q.delete();
      m_wb_we = 0;
      m_err   = 0;
    end else begin
      mdl_was_hold = m_hold_vld;
      mdl_issue    = m_hold_vld && (m_q.size() < MAX) && !flush_i;
      m_wb_we = 0;
      m_err   = 0;
      if (bus.bus_rvalid_i && m_q.size() > 0) begin
        mdl_e = m_q.pop_front();
        if (!mdl_e.kill && !flush_i) begin
          if (bus.bus_err_i) m_err = 1;
          else if (!mdl_e.we) begin
            m_wb_we   = (mdl_e.rd != 0);
            m_wb_addr = mdl_e.rd;
            m_wb_data = model_align(bus.bus_rdata_i, mdl_e.lane, mdl_e.size, mdl_e.sgn);
          end
        end
      end
      if (flush_i) begin
        foreach (m_q[i]) m_q[i].kill = 1'b1;
        m_hold_vld = 0;
      end
      if (mdl_issue && bus.bus_gnt_i) begin
        m_q.push_back('{we: m_hold.we, lane: m_hold.addr[1:0], size: m_hold.size,
                        sgn: m_hold.sgn, rd: m_hold.rd, kill: 1'b0});
        m_hold_vld = 0;
      end
      if (!mdl_was_hold && req_valid_i && !flush_i) begin
        m_hold = '{we: req_we_i, addr: req_addr_i, wdata: req_wdata_i, wmask: req_wmask_i,
                   size: req_size_i, sgn: req_signed_i, rd: req_rd_i};
        m_hold_vld = 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison against the model, mid-cycle while inputs are stable.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("m_req_ready", req_ready_o, !m_hold_vld);
      checkOutput("m_bus_req", bus.bus_req_o, m_hold_vld && (m_q.size() < MAX) && !flush_i);
      checkOutput("m_idle", lsu_idle_o, !m_hold_vld && (m_q.size() == 0));
      checkOutput("m_wb_we", wb_we_o, m_wb_we);
      checkOutput("m_err", err_o, m_err);
      if (m_hold_vld) begin
        checkOutput("m_bus_we", bus.bus_we_o, m_hold.we);
        checkOutput("m_bus_addr", bus.bus_addr_o, m_hold.addr);
        checkOutput("m_bus_wdata", bus.bus_wdata_o, m_hold.wdata);
        checkOutput("m_bus_wmask", bus.bus_wmask_o, m_hold.wmask);
      end
      if (m_wb_we) begin
        checkOutput("m_wb_waddr", wb_waddr_o, m_wb_addr);
        checkOutput("m_wb_wdata", wb_wdata_o, m_wb_data);
      end
    end
  end

  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_inputs();
    req_valid_i = 0; req_we_i = 0; req_addr_i = '0; req_wdata_i = '0;
    req_wmask_i = '0; req_size_i = '0; req_signed_i = 0; req_rd_i = '0;
    flush_i = 0;
    bus.bus_gnt_i = 0; bus.bus_rvalid_i = 0; bus.bus_rdata_i = '0; bus.bus_err_i = 0;
  endtask

  task automatic set_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wmask, input logic [1:0] size,
                         input logic sgn, input logic [4:0] rd);
    req_valid_i = 1; req_we_i = we; req_addr_i = addr; req_wdata_i = wdata;
    req_wmask_i = wmask; req_size_i = size; req_signed_i = sgn; req_rd_i = rd;
  endtask

  // Accept, immediate grant, response next cycle; returns when wb is visible.
  task automatic run_load(input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                          input logic [4:0] rd, input logic [31:0] rdata);
    set_req(0, addr, '0, '0, size, sgn, rd);
    applyStimulus(1);
    req_valid_i = 0;
    bus.bus_gnt_i = 1;
    #1;
    checkOutput("ld_bus_req", bus.bus_req_o, 1);
    checkOutput("ld_bus_addr", bus.bus_addr_o, addr);
    applyStimulus(1);
    bus.bus_gnt_i = 0;
    bus.bus_rvalid_i = 1;
    bus.bus_rdata_i = rdata;
    checkOutput("ld_no_early_wb", wb_we_o, 0);
    applyStimulus(1);
    bus.bus_rvalid_i = 0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clear_inputs();
    rst = 1;
    applyStimulus(2);
    checkOutput("rst_ready", req_ready_o, 1);
    checkOutput("rst_idle", lsu_idle_o, 1);
    checkOutput("rst_bus_req", bus.bus_req_o, 0);
    checkOutput("rst_wb_we", wb_we_o, 0);
    checkOutput("rst_err", err_o, 0);
    rst = 0;
    applyStimulus(1);

    $display("[TB] signed byte load");
    run_load(32'h0000_1003, 2'b00, 1, 5'd5, 32'h80FF_1234);
    checkOutput("lb_wb_we", wb_we_o, 1);
    checkOutput("lb_wb_waddr", wb_waddr_o, 5);
    checkOutput("lb_wb_wdata", wb_wdata_o, 32'hFFFF_FF80);
    applyStimulus(1);
    checkOutput("lb_wb_pulse", wb_we_o, 0);

    $display("[TB] halfword and word loads");
    run_load(32'h0000_2002, 2'b01, 0, 5'd7, 32'h8765_4321);
    checkOutput("lhu_wb_we", wb_we_o, 1);
    checkOutput("lhu_wb_wdata", wb_wdata_o, 32'h0000_8765);
    run_load(32'h0000_2000, 2'b01, 1, 5'd6, 32'h0000_9ABC);
    checkOutput("lh_wb_wdata", wb_wdata_o, 32'hFFFF_9ABC);
    run_load(32'h0000_2001, 2'b00, 0, 5'd4, 32'h0000_F200);
    checkOutput("lbu_wb_wdata", wb_wdata_o, 32'h0000_00F2);
    run_load(32'h0000_4000, 2'b10, 0, 5'd0, 32'hDEAD_BEEF);
    checkOutput("lw_x0_wb_we", wb_we_o, 0);
    applyStimulus(1);

    $display("[TB] spurious response while idle");
    bus.bus_rvalid_i = 1; bus.bus_err_i = 1; bus.bus_rdata_i = 32'h1234_5678;
    applyStimulus(1);
    bus.bus_rvalid_i = 0; bus.bus_err_i = 0;
    checkOutput("spur_wb_we", wb_we_o, 0);
    checkOutput("spur_err", err_o, 0);
    checkOutput("spur_idle", lsu_idle_o, 1);

    $display("[TB] stalled store");
    set_req(1, 32'h0000_3001, 32'h0000_AB00, 4'b0010, 2'b00, 0, 5'd0);
    applyStimulus(1);
    req_valid_i = 0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("sb_stall_req", bus.bus_req_o, 1);
      checkOutput("sb_stall_we", bus.bus_we_o, 1);
      checkOutput("sb_stall_addr", bus.bus_addr_o, 32'h0000_3001);
      checkOutput("sb_stall_wdata", bus.bus_wdata_o, 32'h0000_AB00);
      checkOutput("sb_stall_wmask", bus.bus_wmask_o, 4'b0010);
      applyStimulus(1);
    end
    bus.bus_gnt_i = 1;
    applyStimulus(1);
    bus.bus_gnt_i = 1;
    checkOutput("sb_single_grant", bus.bus_req_o, 0);
    checkOutput("sb_busy", lsu_idle_o, 0);
    bus.bus_gnt_i = 0;
    bus.bus_rvalid_i = 1; bus.bus_rdata_i = 32'hFFFF_FFFF;
    applyStimulus(1);
    bus.bus_rvalid_i = 0;
    checkOutput("sb_no_wb", wb_we_o, 0);
    checkOutput("sb_idle", lsu_idle_o, 1);

    $display("[TB] outstanding limit");
    bus.bus_gnt_i = 1;
    set_req(0, 32'h0000_0100, '0, '0, 2'b10, 0, 5'd1);
    applyStimulus(1);
    set_req(0, 32'h0000_0104, '0, '0, 2'b10, 0, 5'd2);
    applyStimulus(2);
    set_req(0, 32'h0000_0108, '0, '0, 2'b10, 0, 5'd3);
    applyStimulus(2);
    req_valid_i = 0;
    checkOutput("lim_bus_req", bus.bus_req_o, 0);
    checkOutput("lim_ready", req_ready_o, 0);
    applyStimulus(1);
    checkOutput("lim_bus_req2", bus.bus_req_o, 0);
    checkOutput("lim_ready2", req_ready_o, 0);
    bus.bus_rvalid_i = 1; bus.bus_rdata_i = 32'h1111_1111;
    applyStimulus(1);
    checkOutput("lim_issue3", bus.bus_req_o, 1);
    checkOutput("lim_wb1_addr", wb_waddr_o, 1);
    checkOutput("lim_wb1_data", wb_wdata_o, 32'h1111_1111);
    bus.bus_rdata_i = 32'h2222_2222;
    applyStimulus(1);
    bus.bus_gnt_i = 0;
    checkOutput("lim_granted3", bus.bus_req_o, 0);
    checkOutput("lim_wb2_addr", wb_waddr_o, 2);
    checkOutput("lim_wb2_data", wb_wdata_o, 32'h2222_2222);
    bus.bus_rdata_i = 32'h3333_3333;
    applyStimulus(1);
    bus.bus_rvalid_i = 0;
    checkOutput("lim_wb3_we", wb_we_o, 1);
    checkOutput("lim_wb3_addr", wb_waddr_o, 3);
    checkOutput("lim_wb3_data", wb_wdata_o, 32'h3333_3333);
    checkOutput("lim_idle", lsu_idle_o, 1);
    applyStimulus(1);

    $display("[TB] flush");
    set_req(0, 32'h0000_0200, '0, '0, 2'b10, 0, 5'd8);
    applyStimulus(1);
    bus.bus_gnt_i = 1;
    set_req(0, 32'h0000_0204, '0, '0, 2'b10, 0, 5'd9);
    applyStimulus(1);
    bus.bus_gnt_i = 0;
    applyStimulus(1);
    req_valid_i = 0;
    bus.bus_gnt_i = 1;
    flush_i = 1;
    #1;
    checkOutput("fl_req_blocked", bus.bus_req_o, 0);
    applyStimulus(1);
    flush_i = 0;
    bus.bus_gnt_i = 0;
    checkOutput("fl_dropped", bus.bus_req_o, 0);
    checkOutput("fl_ready", req_ready_o, 1);
    checkOutput("fl_busy", lsu_idle_o, 0);
    bus.bus_rvalid_i = 1; bus.bus_rdata_i = 32'h5555_5555;
    applyStimulus(1);
    bus.bus_rvalid_i = 0;
    checkOutput("fl_killed_wb", wb_we_o, 0);
    checkOutput("fl_killed_err", err_o, 0);
    checkOutput("fl_idle", lsu_idle_o, 1);
    flush_i = 1;
    set_req(0, 32'h0000_0210, '0, '0, 2'b10, 0, 5'd12);
    applyStimulus(1);
    flush_i = 0;
    req_valid_i = 0;
    checkOutput("fl_no_accept", req_ready_o, 1);
    run_load(32'h0000_0208, 2'b10, 0, 5'd10, 32'h6666_6666);
    checkOutput("fl_after_we", wb_we_o, 1);
    checkOutput("fl_after_addr", wb_waddr_o, 10);
    checkOutput("fl_after_data", wb_wdata_o, 32'h6666_6666);

    $display("[TB] bus error");
    set_req(0, 32'h0000_0300, '0, '0, 2'b10, 0, 5'd11);
    applyStimulus(1);
    req_valid_i = 0;
    bus.bus_gnt_i = 1;
    applyStimulus(1);
    bus.bus_gnt_i = 0;
    bus.bus_rvalid_i = 1; bus.bus_err_i = 1; bus.bus_rdata_i = 32'h7777_7777;
    applyStimulus(1);
    bus.bus_rvalid_i = 0; bus.bus_err_i = 0;
    checkOutput("err_pulse", err_o, 1);
    checkOutput("err_no_wb", wb_we_o, 0);
    applyStimulus(1);
    checkOutput("err_clear", err_o, 0);

    $display("[TB] async reset mid-transaction");
    set_req(0, 32'h0000_0400, '0, '0, 2'b10, 0, 5'd12);
    applyStimulus(1);
    bus.bus_gnt_i = 1;
    set_req(0, 32'h0000_0404, '0, '0, 2'b10, 0, 5'd13);
    applyStimulus(1);
    bus.bus_gnt_i = 0;
    applyStimulus(1);
    req_valid_i = 0;
    checkOutput("mid_busy", lsu_idle_o, 0);
    checkOutput("mid_not_ready", req_ready_o, 0);
    rst = 1;
    #1;
    checkOutput("arst_ready", req_ready_o, 1);
    checkOutput("arst_bus_req", bus.bus_req_o, 0);
    checkOutput("arst_idle", lsu_idle_o, 1);
    checkOutput("arst_wb_we", wb_we_o, 0);
    checkOutput("arst_err", err_o, 0);
    applyStimulus(2);
    rst = 0;
    applyStimulus(2);
    checkOutput("post_rst_idle", lsu_idle_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_bus_ctrl.md
Name: lsu_bus_ctrl

Overview:
- Memory-stage bus controller directly downstream of the address generation unit.
- Registers one load/store request into a holding slot and issues it on a req/gnt bus.
- Tracks up to MAX_OUTSTANDING in-order responses. Aligns and sign/zero-extends load data, then produces a registered register-file writeback.
- Provides upstream back-pressure and interrupt/flush squashing.

Parameters:
- ADDR_W, 32, bus address width
- DATA_W, 32, bus data width (fixed 32 for lane logic)
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered transactions (power of two, ≥1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_valid_i  in  1  AGU request valid
- req_ready_o  out  1  holding slot free; accept when valid&ready
- req_we_i  in  1  1=store, 0=load
- req_addr_i  in  ADDR_W  byte address
- req_wdata_i  in  32  lane-positioned store data
- req_wmask_i  in  4  store byte mask
- req_size_i  in  2  00 byte, 01 half, 10 word
- req_signed_i  in  1  sign-extend load
- req_rd_i  in  5  load destination register
- flush_i  in  1  interrupt/flush squash
- bus_req_o  out  1  bus request
- bus_gnt_i  in  1  bus grant
- bus_we_o  out  1  bus write
- bus_addr_o  out  ADDR_W  bus address
- bus_wdata_o  out  32  bus write data
- bus_wmask_o  out  4  bus byte mask
- bus_rvalid_i  in  1  in-order response valid (one per granted transaction, loads and stores)
- bus_rdata_i  in  32  response data
- bus_err_i  in  1  response error, qualified by rvalid
- wb_we_o  out  1  writeback enable, one-cycle pulse
- wb_waddr_o  out  5  writeback register
- wb_wdata_o  out  32  aligned load data
- err_o  out  1  bus error pulse
- lsu_idle_o  out  1  no held or outstanding transaction

Behaviour:
- Reset (async): hold_vld=0, outstanding count=0, metadata FIFO empty, all kill bits 0. All outputs 0 except req_ready_o=1 and lsu_idle_o=1.
- Clock/reset naming: clk is the single clock; rst is the asynchronous, active-high reset.
- Acceptance: req_ready_o = ~hold_vld, registered-only path with no combinational dependence on gnt. On accept, latch we/addr/wdata/wmask/size/signed/rd. Set hold_vld at the next edge.
- Issue:
  - bus_req_o = hold_vld & (cnt < MAX_OUTSTANDING) & ~flush_i.
  - Bus fields are driven from the hold register and remain stable while bus_req_o is high without gnt.
  - On bus_req_o & bus_gnt_i: clear hold_vld, increment cnt, push metadata {we, addr[1:0], size, signed, rd, kill=0}.
  - A new request may be accepted only in the cycle after hold_vld clears; issue is therefore one per 2 cycles at most from a single slot.
- Response:
  - On bus_rvalid_i: pop the FIFO head and decrement cnt.
  - Grant and response in the same cycle leave cnt unchanged.
  - rvalid with cnt==0 is ignored and asserts nothing.
- Load writeback is registered. In the cycle after rvalid, for a non-killed load with ~bus_err_i:
  - wb_we_o=1 when rd≠0, and 0 for x0.
  - Byte: lane addr[1:0] 0..3 → rdata[7:0]/[15:8]/[23:16]/[31:24].
  - Half: addr[1]=0 → [15:0], 1 → [31:16].
  - Word: full rdata.
  - Extension: sign when signed=1, else zero.
  - Stores produce no writeback.
- Error: rvalid & bus_err_i on a non-killed entry gives err_o=1 for one cycle (registered) and suppresses writeback.
- Flush:
  - In the flush_i cycle, a held but ungranted request is dropped (hold_vld←0) and no request is accepted (req_ready_o ignored).
  - All FIFO entries present that cycle get kill=1. Their responses are still consumed and counted but produce no wb/err.
  - Entries pushed after flush are live.
  - flush_i has priority over gnt in the same cycle, because bus_req_o is already 0.
- Latency: accept at edge N; bus_req_o high in cycle N+1. With gnt in N+1, the earliest rvalid is N+2 and wb_we_o is high in N+3.
- Back-pressure: with cnt==MAX, bus_req_o=0 and hold_vld persists, so req_ready_o stays low.
- lsu_idle_o = ~hold_vld & (cnt==0).

Test Plan:
- LB signed: addr 0x1003, rd=5, gnt immediate, rdata 0x80FF_1234 next cycle → bus_addr_o=0x1003, wb_we_o=1 at accept+3, wb_waddr_o=5, wb_wdata_o=0xFFFF_FF80.
- LHU addr 0x2002 rdata 0x8765_4321 → 0x0000_8765. LW rd=0 → wb_we_o=0.
- SB addr 0x3001 wmask 0010 wdata 0x0000_AB00, gnt held low 3 cycles → bus fields stable across the stall; single grant; rvalid → no wb; cnt returns to 0; lsu_idle_o=1.
- Three back-to-back loads, rvalid withheld → after 2 grants bus_req_o=0, req_ready_o=0. One rvalid → third issues; responses return in order with matching rd.
- flush_i with one load granted and one held → held one dropped (no bus_req_o); granted load's rvalid yields no wb; next load after flush writes back normally.
- rvalid+bus_err_i on a load → err_o one-cycle pulse, wb_we_o=0. Async rst asserted mid-transaction → all outputs return to reset values immediately.
